// File: rtl/image_loader.sv
// Image fetch engine: streams img_size*img_size*num_ch words from memory in
// BLOCK-word beats into a local buffer read through a registered port.
module image_loader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned BLOCK  = 150,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned SIZE_W = 6,
    parameter int unsigned CH_W   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [SIZE_W-1:0]          img_size,
    input  logic [CH_W-1:0]            num_ch,
    input  logic [ADDR_W-1:0]          base_addr,
    output logic                       mem_rd,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_valid,
    input  logic [BLOCK*DATA_W-1:0]    mem_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] words_loaded,
    input  logic [$clog2(DEPTH)-1:0]   buf_rd_addr,
    output logic [DATA_W-1:0]          buf_rd_data
);
    localparam int unsigned TOT_W = 2*SIZE_W + CH_W;
    localparam int unsigned WL_W  = $clog2(DEPTH+1);
    localparam int unsigned RA_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t              state_q, state_d;
    logic [TOT_W-1:0]    total_q, total_d;
    logic [TOT_W-1:0]    off_q, off_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [WL_W-1:0]     wl_q, wl_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [DATA_W-1:0]   buf_q [DEPTH];

    logic [TOT_W-1:0]    tot_c;
    logic [TOT_W-1:0]    wr_cnt_c;
    logic                last_c;
    logic                wr_en_c;

    // Block bookkeeping: off_q is the buffer offset of the current block
    always_comb begin
        tot_c    = TOT_W'(img_size) * TOT_W'(img_size) * TOT_W'(num_ch);
        last_c   = (off_q + TOT_W'(BLOCK)) >= total_q;
        wr_cnt_c = last_c ? (total_q - off_q) : TOT_W'(BLOCK);
        wr_en_c  = (state_q == FETCH) && mem_valid;
    end

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        off_d    = off_q;
        addr_d   = addr_q;
        mem_rd_d = mem_rd_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        wl_d     = wl_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    total_d = tot_c;
                    off_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    wl_d    = '0;
                    if (tot_c == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (tot_c > TOT_W'(DEPTH)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = FETCH;
                        addr_d   = base_addr;
                        mem_rd_d = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (mem_valid) begin
                    wl_d = wl_q + WL_W'(wr_cnt_c);
                    if (last_c) begin
                        state_d  = DONE;
                        mem_rd_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        off_d  = off_q + TOT_W'(BLOCK);
                        addr_d = addr_q + ADDR_W'(BLOCK);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            total_q  <= '0;
            off_q    <= '0;
            addr_q   <= '0;
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wl_q     <= '0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            mem_rd_q <= mem_rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wl_q     <= wl_d;
        end
    end

    // Buffer survives reset; words of a partial block past total are dropped
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int i = 0; i < int'(BLOCK); i++) begin
                if (TOT_W'(i) < wr_cnt_c) begin
                    buf_q[RA_W'(off_q + TOT_W'(i))] <= mem_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        rd_data_d = buf_q[buf_rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign mem_rd       = mem_rd_q;
    assign mem_addr     = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = wl_q;
    assign buf_rd_data  = rd_data_q;

endmodule
